// File: rtl/counter_ctrl.sv
// Command sequencer driving an 8-bit loadable up-counter through LOAD/STEP/UNTIL/SHOW commands.
// Optional UNTIL timeout abort is enabled by defining COUNTER_CTRL_TIMEOUT_EN.
module counter_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [WIDTH-1:0] ctr_q,
  output logic             ctr_en,
  output logic             ctr_load,
  output logic [WIDTH-1:0] ctr_load_val,
  output logic             ctr_oe,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStep,
    StUntil,
    StShow,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             match;
  logic             timeout_hit;

`ifdef COUNTER_CTRL_TIMEOUT_EN
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;

  assign timeout_hit = (to_q == 8'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  assign match     = (ctr_q == arg_q);
  assign cmd_ready = (state_q == StIdle) && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      arg_q   <= '0;
      step_q  <= '0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      step_q  <= step_d;
`ifdef COUNTER_CTRL_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    step_d  = step_q;
`ifdef COUNTER_CTRL_TIMEOUT_EN
    to_d    = to_q;
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          arg_d  = cmd_arg;
          step_d = cmd_arg;
`ifdef COUNTER_CTRL_TIMEOUT_EN
          to_d   = '0;
          err_d  = 1'b0;
`endif
          unique case (cmd_op)
            2'b00: state_d = StLoad;
            2'b01: state_d = StStep;
            2'b10: state_d = StUntil;
            2'b11: state_d = StShow;
            default: state_d = StIdle;
          endcase
        end
      end
      StLoad: state_d = StDone;
      // STEP and SHOW share the down-counter; the zero cycle is the exit cycle.
      StStep, StShow: begin
        if (step_q == '0) begin
          state_d = StDone;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      StUntil: begin
        if (match) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
`ifdef COUNTER_CTRL_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef COUNTER_CTRL_TIMEOUT_EN
          to_d = to_q + 8'd1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; en/load/oe are exclusive because each is tied to a distinct state.
  always_comb begin
    ctr_en       = 1'b0;
    ctr_load     = 1'b0;
    ctr_oe       = 1'b0;
    ctr_load_val = arg_q;
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    case (state_q)
      StLoad:  ctr_load = 1'b1;
      StStep:  ctr_en   = (step_q != '0);
      StUntil: ctr_en   = !match && !timeout_hit;
      StShow:  ctr_oe   = (step_q != '0);
      default: ;
    endcase
`ifdef COUNTER_CTRL_TIMEOUT_EN
    err = done && err_q;
`else
    err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: table-driven command vectors plus directed corner cases.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [7:0] ctr_q = 8'h00;
  logic       ctr_en;
  logic       ctr_load;
  logic [7:0] ctr_load_val;
  logic       ctr_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic       freeze = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8), .TIMEOUT(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .ctr_q        (ctr_q),
    .ctr_en       (ctr_en),
    .ctr_load     (ctr_load),
    .ctr_load_val (ctr_load_val),
    .ctr_oe       (ctr_oe),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Counter datapath model
  always @(posedge clk) begin
    if (!freeze) begin
      if (ctr_load) ctr_q <= ctr_load_val;
      else if (ctr_en) ctr_q <= ctr_q + 8'd1;
    end
  end

  always @(negedge clk) begin
    if ((int'(ctr_en) + int'(ctr_load) + int'(ctr_oe)) > 1) excl_viol++;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    int         en;
    int         ld;
    int         oe;
    int         lat;
    logic [7:0] q;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cmd_ready; i++) step();
    check("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, output int lat,
                         output int en, output int ld, output int oe, output logic errv,
                         output logic [7:0] q, output logic ldval_ok, output logic got_done);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
    lat = 1; en = 0; ld = 0; oe = 0; errv = 1'b0; q = 8'h00;
    ldval_ok = 1'b1; got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      en += int'(ctr_en);
      ld += int'(ctr_load);
      oe += int'(ctr_oe);
      if (ctr_load && ctr_load_val !== arg) ldval_ok = 1'b0;
      if (done) begin
        got_done = 1'b1;
        errv = err;
        q = ctr_q;
        break;
      end
      step();
      lat++;
    end
    check("done_seen", 32'(got_done), 32'd1);
  endtask

  int         lat, en, ld, oe, rdy_seen, dcnt;
  logic       errv, ldok, got;
  logic [7:0] q;

  initial begin
    vecs[0] = '{2'b00, 8'hA5, 0, 1, 0, 2,  8'hA5};
    vecs[1] = '{2'b01, 8'd4,  4, 0, 0, 6,  8'hA9};
    vecs[2] = '{2'b01, 8'd0,  0, 0, 0, 2,  8'hA9};
    vecs[3] = '{2'b00, 8'd250, 0, 1, 0, 2, 8'd250};
    vecs[4] = '{2'b10, 8'd3,  9, 0, 0, 11, 8'd3};
    vecs[5] = '{2'b10, 8'd3,  0, 0, 0, 2,  8'd3};
    vecs[6] = '{2'b11, 8'd5,  0, 0, 5, 7,  8'd3};
    vecs[7] = '{2'b11, 8'd0,  0, 0, 0, 2,  8'd3};
    vecs[8] = '{2'b00, 8'hFF, 0, 1, 0, 2,  8'hFF};
    vecs[9] = '{2'b01, 8'd2,  2, 0, 0, 4,  8'h01};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs", {26'd0, ctr_en, ctr_load, ctr_oe, busy, done, err}, 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd0);
    end
    check("rst_ldval", 32'(ctr_load_val), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    for (int v = 0; v < 10; v++) begin
      run_cmd(vecs[v].op, vecs[v].arg, lat, en, ld, oe, errv, q, ldok, got);
      check($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("v%0d_en", v), 32'(en), 32'(vecs[v].en));
      check($sformatf("v%0d_ld", v), 32'(ld), 32'(vecs[v].ld));
      check($sformatf("v%0d_oe", v), 32'(oe), 32'(vecs[v].oe));
      check($sformatf("v%0d_q", v), 32'(q), 32'(vecs[v].q));
      check($sformatf("v%0d_err", v), 32'(errv), 32'd0);
      check($sformatf("v%0d_ldval", v), 32'(ldok), 32'd1);
      step();
      check($sformatf("v%0d_ready_after", v), {30'd0, cmd_ready, done}, 32'd2);
    end

    // SHOW 5 with a LOAD held on the command port
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = 8'd5;
    step();
    cmd_op = 2'b00; cmd_arg = 8'h11;
    oe = 0; rdy_seen = 0; lat = 1;
    for (int i = 0; i < 50; i++) begin
      oe += int'(ctr_oe);
      rdy_seen += int'(cmd_ready);
      if (done) break;
      step();
      lat++;
    end
    check("held_oe", 32'(oe), 32'd5);
    check("held_ready_low", 32'(rdy_seen), 32'd0);
    check("held_lat", 32'(lat), 32'd7);
    step();
    check("held_accept_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check("held_load", 32'(ctr_load), 32'd1);
    check("held_ldval", 32'(ctr_load_val), 32'h11);
    step();
    check("held_done", 32'(done), 32'd1);
    check("held_q", 32'(ctr_q), 32'h11);
    step();

    // Reset in the middle of SHOW
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = 8'd10;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("mid_oe", 32'(ctr_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    step();
    check("mid_rst_outs", {29'd0, ctr_oe, busy, done}, 32'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      dcnt += int'(done);
      step();
    end
    check("mid_no_done", 32'(dcnt), 32'd0);
    check("mid_ready", 32'(cmd_ready), 32'd1);

`ifdef COUNTER_CTRL_TIMEOUT_EN
    run_cmd(2'b00, 8'h00, lat, en, ld, oe, errv, q, ldok, got);
    step();
    freeze = 1'b1;
    run_cmd(2'b10, 8'h55, lat, en, ld, oe, errv, q, ldok, got);
    check("to_en", 32'(en), 32'd10);
    check("to_lat", 32'(lat), 32'd12);
    check("to_err", 32'(errv), 32'd1);
    check("to_q", 32'(q), 32'd0);
    freeze = 1'b0;
    step();
`endif

    check("exclusive_ctrl", 32'(excl_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
